// File: rtl/note_phase_acc_pkg.sv
// Shared defaults and state encoding for the note phase accumulator.
package note_phase_acc_pkg;
  localparam int NPA_PHASE_W  = 10;
  localparam int NPA_JUMP_W   = 7;
  localparam int NPA_REM_W    = 29;
  localparam int NPA_FRAC_MOD = 100000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DRAIN = 2'd2
  } npa_state_e;
endpackage

// File: rtl/note_phase_acc_frac_step.sv
// Fractional step: clamp the remainder, add to frac, fold back modulo FRAC_MOD with carry.
module note_phase_acc_frac_step
  import note_phase_acc_pkg::*;
#(
  parameter int REM_W    = NPA_REM_W,
  parameter int FRAC_MOD = NPA_FRAC_MOD
) (
  input  logic [REM_W-1:0] frac,
  input  logic [REM_W-1:0] rem,
  output logic [REM_W-1:0] frac_nxt,
  output logic             c
);
  localparam logic [REM_W-1:0] MOD_M1 = REM_W'(FRAC_MOD - 1);
  localparam logic [REM_W:0]   MOD    = (REM_W+1)'(FRAC_MOD);

  logic [REM_W-1:0] rem_eff;
  logic [REM_W:0]   sum;

  always_comb begin
    rem_eff  = (rem > MOD_M1) ? MOD_M1 : rem;
    sum      = {1'b0, frac} + {1'b0, rem_eff};
    c        = (sum >= MOD);
    frac_nxt = c ? REM_W'(sum - MOD) : sum[REM_W-1:0];
  end
endmodule

// File: rtl/note_phase_acc.sv
// Fractional phase accumulator with gated start and wrap-aligned release.
// Optional macro PHASE_ROUND_EN rounds the phase output to the nearest table entry.
module note_phase_acc
  import note_phase_acc_pkg::*;
#(
  parameter int PHASE_W  = NPA_PHASE_W,
  parameter int JUMP_W   = NPA_JUMP_W,
  parameter int REM_W    = NPA_REM_W,
  parameter int FRAC_MOD = NPA_FRAC_MOD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               gate,
  input  logic [JUMP_W-1:0]  jump,
  input  logic [REM_W-1:0]   remainder,
  output logic [PHASE_W-1:0] phase,
  output logic               phase_valid,
  output logic               wrap,
  output logic               active
);
  npa_state_e         st, st_nxt;
  logic [PHASE_W-1:0] ph_reg, ph_nxt, base_ph, step_ph;
  logic [REM_W-1:0]   frac, fr_nxt, base_fr, step_fr;
  logic               gate_q, rise, fall, start, step_c, step_w, zero_inc, wrap_nxt;

  assign rise     = gate & ~gate_q;
  assign fall     = ~gate & gate_q;
  assign start    = (st == ST_IDLE) && rise;
  assign zero_inc = (jump == '0) && (remainder == '0);

  // A start clears phase/frac before the increment so a coincident tick steps from 0.
  assign base_ph = start ? '0 : ph_reg;
  assign base_fr = start ? '0 : frac;

  note_phase_acc_frac_step #(.REM_W(REM_W), .FRAC_MOD(FRAC_MOD)) u_step (
    .frac     (base_fr),
    .rem      (remainder),
    .frac_nxt (step_fr),
    .c        (step_c)
  );

  assign {step_w, step_ph} = {1'b0, base_ph} + (PHASE_W+1)'(jump) + (PHASE_W+1)'(step_c);

  always_comb begin
    st_nxt   = st;
    ph_nxt   = base_ph;
    fr_nxt   = base_fr;
    wrap_nxt = 1'b0;
    if (tick && (st != ST_IDLE || start)) begin
      ph_nxt   = step_ph;
      fr_nxt   = step_fr;
      wrap_nxt = step_w;
    end
    case (st)
      ST_IDLE:  if (rise) st_nxt = ST_PLAY;
      ST_PLAY:  if (fall) st_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (rise) st_nxt = ST_PLAY;
        else if (tick && (step_w || zero_inc)) begin
          st_nxt = ST_IDLE;
          ph_nxt = '0;
          fr_nxt = '0;
        end
      end
      default:  st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st          <= ST_IDLE;
      ph_reg      <= '0;
      frac        <= '0;
      phase_valid <= 1'b0;
      wrap        <= 1'b0;
      // Track gate through reset so a held gate does not look like a new note.
      gate_q      <= gate;
    end else begin
      st          <= st_nxt;
      ph_reg      <= ph_nxt;
      frac        <= fr_nxt;
      phase_valid <= tick;
      wrap        <= wrap_nxt;
      gate_q      <= gate;
    end
  end

  assign active = (st != ST_IDLE);

`ifdef PHASE_ROUND_EN
  localparam logic [REM_W-1:0] HALF = REM_W'(FRAC_MOD / 2);
  assign phase = ph_reg + PHASE_W'(frac >= HALF);
`else
  assign phase = ph_reg;
`endif
endmodule

// File: tb/tb_note_phase_acc.sv
// Randomized + directed bench for note_phase_acc against a total-position reference model.
module tb_note_phase_acc;
  localparam longint MOD  = 100000000;
  localparam longint SPAN = 1024 * MOD;

  logic        clk = 1'b0;
  logic        rst_n, tick, gate;
  logic [6:0]  jump;
  logic [28:0] remainder;
  logic [9:0]  phase;
  logic        phase_valid, wrap, active;

  int n_chk = 0, n_pass = 0;

  note_phase_acc dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .gate(gate), .jump(jump),
    .remainder(remainder), .phase(phase), .phase_valid(phase_valid),
    .wrap(wrap), .active(active)
  );

  always #5 clk = ~clk;

  // Model: position as one integer in units of 1/MOD table steps, modulo the table span.
  longint m_tot;
  int     m_st;     // 0 idle, 1 play, 2 drain
  bit     m_gq, m_valid, m_wrap, chk_en;

  always @(posedge clk) begin : model
    bit rise, fall, w;
    int prev;
    longint inc, nt;
    if (!rst_n) begin
      m_tot = 0; m_st = 0; m_valid = 0; m_wrap = 0; m_gq = gate;
    end else begin
      rise = gate && !m_gq;
      fall = !gate && m_gq;
      m_gq = gate;
      m_valid = tick;
      m_wrap = 0;
      prev = m_st;
      if (prev == 0 && rise) begin m_st = 1; m_tot = 0; end
      else if (prev == 1 && fall) m_st = 2;
      else if (prev == 2 && rise) m_st = 1;
      if (tick && m_st != 0) begin
        inc = longint'(jump) * MOD + ((longint'(remainder) >= MOD) ? MOD - 1 : longint'(remainder));
        nt = m_tot + inc;
        w = (nt >= SPAN);
        m_tot = nt % SPAN;
        m_wrap = w;
        if (prev == 2 && !rise && (w || (jump == 0 && remainder == 0))) begin
          m_st = 0; m_tot = 0;
        end
      end
    end
    chk_en = 1;
  end

  function automatic int m_phase();
`ifdef PHASE_ROUND_EN
    return int'(((m_tot / MOD) + (((m_tot % MOD) >= MOD / 2) ? 1 : 0)) % 1024);
`else
    return int'(m_tot / MOD);
`endif
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc phase",  {22'd0, phase}, m_phase());
      chk("cyc valid",  phase_valid, m_valid);
      chk("cyc wrap",   wrap, m_wrap);
      chk("cyc active", active, (m_st != 0));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  int p0;

  initial begin
    rst_n = 0; tick = 0; gate = 0; jump = 0; remainder = 0;
    repeat (3) step();
    chk("reset phase", phase, 0);
    chk("reset active", active, 0);
    rst_n = 1;
    step();

    // Basic accumulation
    gate = 1; jump = 7'd28; remainder = 29'd16000000;
    step();
    for (int i = 0; i < 25; i++) begin do_tick(); step(); end
    chk("t1 phase", phase, 704);
    chk("t1 model", m_tot, 704 * MOD);

    // Wrap
    rst_n = 0; gate = 0; step(); rst_n = 1; gate = 1; step();
    jump = 7'd63; remainder = 29'd21706256;
    for (int i = 0; i < 16; i++) do_tick();
    chk("t2 phase16", phase, 1011);
    chk("t2 valid", phase_valid, 1);
    do_tick();
`ifdef PHASE_ROUND_EN
    chk("t2 phase17", phase, 51);
`else
    chk("t2 phase17", phase, 50);
`endif
    chk("t2 wrap", wrap, 1);
    chk("t2 model", m_tot / MOD, 50);
    step();
    chk("t2 wrap pulse", wrap, 0);
    chk("t2 valid pulse", phase_valid, 0);

    // Release drains to the next wrap
    gate = 0; step();
    chk("t3 drain active", active, 1);
    for (int i = 0; i < 40 && active; i++) do_tick();
    chk("t3 idle active", active, 0);
    chk("t3 idle phase", phase, 0);
    chk("t3 end wrap", wrap, 1);
    for (int i = 0; i < 3; i++) do_tick();
    chk("t3 idle hold", phase, 0);

    // Zero-increment drain
    gate = 1; jump = 0; remainder = 0; step();
    do_tick(); do_tick();
    gate = 0; step();
    chk("t4 drain", active, 1);
    do_tick();
    chk("t4 idle", active, 0);
    chk("t4 phase", phase, 0);

    // Clamp and retune, start coincident with a tick
    jump = 7'd1; remainder = 29'd150000000; gate = 1;
    do_tick();
`ifdef PHASE_ROUND_EN
    chk("t5 tick1", phase, 2);
    do_tick(); chk("t5 tick2", phase, 4);
`else
    chk("t5 tick1", phase, 1);
    do_tick(); chk("t5 tick2", phase, 3);
`endif
    do_tick(); do_tick();
    p0 = phase;
    jump = 7'd16;
    do_tick();
    chk("t5 retune", phase, (p0 + 17) % 1024);

    // Reset mid-play
    rst_n = 0; step(); rst_n = 1;
    chk("t6 phase", phase, 0);
    chk("t6 active", active, 0);
    chk("t6 valid", phase_valid, 0);
    do_tick(); do_tick();
    chk("t6 no start", active, 0);
    gate = 0; step(); gate = 1; step();
    chk("t6 restart", active, 1);

    // Random
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      tick  = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 99) < 8) gate = ~gate;
      if ($urandom_range(0, 99) < 20) begin
        jump = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(0, 127));
        case ($urandom_range(0, 9))
          0: remainder = 0;
          1: remainder = 29'($urandom_range(100000000, 536870911));
          default: remainder = 29'($urandom_range(0, 99999999));
        endcase
      end
      step();
    end
    tick = 0; rst_n = 1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
